// File: rtl/multdiv_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide unit.
interface multdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes).
// Fixed latency of WIDTH+1 cycles from the capture edge to the RDY pulse.
// Optional macro MULTDIV_DIV_EN: when defined the full divider is built; when
// undefined a divide start completes one cycle later with result 0, exception 1.
module multdiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;

    // Booth datapath: prod_q = {accumulator, multiplier, previous multiplier bit}
    logic [WIDTH-1:0] mcand_q;
    logic [PW-1:0]    prod_q;
    logic [PW-1:0]    prod_d;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   mul_hi;
    logic [WIDTH-1:0] mul_res_c;
    logic             mul_exc_c;

    // One Booth step; the add/sub is one bit wider so the shifted-in sign is the true sign
    always_comb begin
        acc_ext   = {prod_q[PW-1], prod_q[PW-1 -: WIDTH]};
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        sum_ext   = acc_ext;
        case (prod_q[1:0])
            2'b01:   sum_ext = acc_ext + mcand_ext;
            2'b10:   sum_ext = acc_ext - mcand_ext;
            default: sum_ext = acc_ext;
        endcase
        prod_d = {sum_ext, prod_q[WIDTH:1]};
    end

    // Product is prod_q[PW-1:1]; it overflows unless bits [2W-1:W-1] are a pure sign extension
    always_comb begin
        mul_hi    = prod_q[PW-1:WIDTH];
        mul_res_c = prod_q[WIDTH:1];
        mul_exc_c = ~((&mul_hi) | (~|mul_hi));
    end

`ifdef MULTDIV_DIV_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_q;
    logic             dz_q;
    logic             ovf_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH-1:0] opa_mag;
    logic [WIDTH-1:0] opb_mag;
    logic [WIDTH-1:0] div_res_c;
    logic             div_exc_c;

    // Operand magnitudes at capture; -MIN wraps to 2^(W-1), which is correct unsigned
    always_comb begin
        opa_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        opb_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    end

    // One restoring shift-subtract step; the dividend register doubles as quotient register
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        if (!rem_sub[WIDTH]) begin
            rem_d = rem_sub[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Final quotient sign fix-up and exception cases
    always_comb begin
        div_exc_c = dz_q | ovf_q;
        if (dz_q) begin
            div_res_c = '0;
        end else if (neg_q) begin
            div_res_c = -quo_q;
        end else begin
            div_res_c = quo_q;
        end
    end

    // Divider operand/iteration registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (bus.ctrl_DIV && !bus.ctrl_MULT) begin
            rem_q <= '0;
            quo_q <= opa_mag;
            dvs_q <= opb_mag;
            neg_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dz_q  <= (bus.data_operandB == '0);
            ovf_q <= (bus.data_operandA == MIN_VAL) && (bus.data_operandB == '1);
        end else if (state_q == S_DIV && cnt_q != LAST_CNT) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end
`endif

    // Control FSM, multiplier registers and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else if (bus.ctrl_MULT) begin
            state_q <= S_MULT;
            cnt_q   <= '0;
            mcand_q <= bus.data_operandA;
            prod_q  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            rdy_q   <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            state_q <= S_DIV;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_MULT: begin
                    if (cnt_q == LAST_CNT) begin
                        result_q <= mul_res_c;
                        exc_q    <= mul_exc_c;
                        rdy_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                S_DIV: begin
`ifdef MULTDIV_DIV_EN
                    if (cnt_q == LAST_CNT) begin
                        result_q <= div_res_c;
                        exc_q    <= div_exc_c;
                        rdy_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`else
                    result_q <= '0;
                    exc_q    <= 1'b1;
                    rdy_q    <= 1'b1;
                    state_q  <= S_DONE;
`endif
                end
                S_DONE: begin
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv.sv
// Bench for multdiv: table of vectors plus hand sequences for restart,
// back-to-back, both-starts and mid-operation reset, checked via a scoreboard.
module tb_multdiv;
`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] held_r = '0;
    logic        held_e = 1'b0;
    vec_t vecs [0:18];

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, independent of the RTL datapath
    function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     q;
        if (is_mult) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            e   = (p != longint'($signed(p[31:0])));
            lat = 33;
        end else if (!DIV_EN) begin
            r   = 32'd0;
            e   = 1'b1;
            lat = 1;
        end else if (b == 32'd0) begin
            r   = 32'd0;
            e   = 1'b1;
            lat = 33;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = 32'h8000_0000;
            e   = 1'b1;
            lat = 33;
        end else begin
            q   = $signed(a) / $signed(b);
            r   = q;
            e   = 1'b0;
            lat = 33;
        end
    endfunction

    function automatic vec_t mv(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic e);
        mv = '{1'b1, 1'b0, a, b, r, e};
    endfunction

    function automatic vec_t dv(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic e);
        dv = '{1'b0, 1'b1, a, b, DIV_EN ? r : 32'd0, DIV_EN ? e : 1'b1};
    endfunction

    // Caller positions us just after a falling edge; the next rising edge is the capture edge
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic e, input int lat);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        sb.delete();
        sb.push_back('{r, e, cyc + 1 + lat});
        @(negedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        int          lat;
        model(m, a, b, r, e, lat);
        start_op(m, d, a, b, r, e, lat);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk32({tag, "_timeout"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Output monitor: RDY only when expected and on the due cycle; outputs hold otherwise
    always @(negedge clock) begin
        if (reset) begin
            if (sb.size() == 0) begin
                chk32("rdy_unexpected", 32'(bus.data_resultRDY), 32'd0);
            end else if (bus.data_resultRDY) begin
                mon_e  = sb.pop_front();
                chk32("rdy_cycle", 32'(cyc), 32'(mon_e.due));
                held_r = mon_e.r;
                held_e = mon_e.e;
            end
            chk32("result", bus.data_result, held_r);
            chk32("exception", 32'(bus.data_exception), 32'(held_e));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mv(32'd3,          32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0);
        vecs[1]  = mv(32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
        vecs[2]  = mv(32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        vecs[3]  = mv(32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1);
        vecs[4]  = mv(32'h8000_0000,  32'h0000_0001, 32'h8000_0000, 1'b0);
        vecs[5]  = mv(32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        vecs[6]  = mv(32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        vecs[7]  = mv(32'h0000_0000,  32'h1234_5678, 32'h0000_0000, 1'b0);
        vecs[8]  = mv(32'h0000_FFFF,  32'h0000_8001, 32'h8000_7FFF, 1'b1);
        vecs[9]  = mv(32'hFFFF_0000,  32'h0000_8000, 32'h8000_0000, 1'b0);
        vecs[10] = dv(32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        vecs[11] = dv(32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        vecs[12] = dv(32'd5,          32'd0,         32'h0000_0000, 1'b1);
        vecs[13] = dv(32'd100,        32'd7,         32'h0000_000E, 1'b0);
        vecs[14] = dv(32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
        vecs[15] = dv(32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
        vecs[16] = dv(32'h7FFF_FFFF,  32'h8000_0000, 32'h0000_0000, 1'b0);
        vecs[17] = dv(32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0);
        vecs[18] = dv(32'h8000_0000,  32'h8000_0000, 32'h0000_0001, 1'b0);

        reset             = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #12;
        chk32("reset_result", bus.data_result, 32'd0);
        chk32("reset_exc", 32'(bus.data_exception), 32'd0);
        chk32("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;

        // Table of single operations
        for (int i = 0; i < 19; i++) begin
            start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e,
                     vecs[i].m ? 33 : (DIV_EN ? 33 : 1));
            wait_done($sformatf("vec%0d", i));
        end

        // Idle: outputs must hold with no RDY
        repeat (40) @(negedge clock);
        #1;

        // Restart: MULT 6*7 aborted by DIV 100/7 captured ten edges later
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (9) @(negedge clock);
        #1;
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        wait_done("restart");
        repeat (40) @(negedge clock);
        #1;

        // Both starts high: multiply wins
        issue(1'b1, 1'b1, 32'd6, 32'd7);
        wait_done("both_starts");

        // Back-to-back: new start driven while RDY of the previous one is high
        issue(1'b1, 1'b0, 32'd12345, 32'hFFFF_FF00);
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            #1;
            if (bus.data_resultRDY) break;
        end
        chk32("b2b_rdy_seen", 32'(bus.data_resultRDY), 32'd1);
        issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd9);
        wait_done("b2b_second");
        issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done("div_after_b2b");
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        wait_done("before_reset");

        // Reset in the middle of a multiply
        issue(1'b1, 1'b0, 32'd1000, 32'd1000);
        repeat (14) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk32("midreset_result", bus.data_result, 32'd0);
        chk32("midreset_exc", 32'(bus.data_exception), 32'd0);
        chk32("midreset_rdy", 32'(bus.data_resultRDY), 32'd0);
        sb.delete();
        held_r = '0;
        held_e = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (50) @(negedge clock);
        #1;
        issue(1'b1, 1'b0, 32'd2, 32'd3);
        wait_done("after_reset");
        repeat (5) @(negedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
